// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access sequencer: RAM size codes,
// FSM state encoding and the request legality rule.
package mem_access_ctrl_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BAD  = 2'b10;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10,
        ST_DONE   = 2'b11
    } state_t;

    // A request is rejected before touching the RAM if its size code is
    // reserved or its address is not naturally aligned for that size.
    function automatic logic is_illegal(input logic [8:0] addr, input logic [1:0] size);
        return (size == SIZE_BAD)
            || (size == SIZE_WORD && addr[1:0] != 2'b00)
            || (size == SIZE_HALF && addr[0]);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_formatter.sv
// Combinational load formatter: selects the valid bytes of a RAM read and
// zero- or sign-extends them to 32 bits.
module mem_access_ctrl_load_formatter
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    // Upper bytes of a byte/halfword read are stale, so they are always replaced.
    always_comb begin
        data = {{24{sign_ext & raw[7]}}, raw[7:0]};
        case (size)
            SIZE_WORD: data = raw;
            SIZE_HALF: data = {{16{sign_ext & raw[15]}}, raw[15:0]};
            default:   data = {{24{sign_ext & raw[7]}}, raw[7:0]};
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer between CPU load/store requests and the 512x8 byte RAM: runs the
// level-sensitive RAM handshake, checks alignment and returns one response per request.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int TO_W           = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [8:0]  reqAddr,
    input  logic [31:0] reqWData,
    input  logic [1:0]  reqSize,
    input  logic        reqSigned,
    output logic        respValid,
    input  logic        respReady,
    output logic [31:0] respRData,
    output logic        respError,
    output logic        memFuncActive,
    output logic        readWrite,
    output logic [8:0]  address,
    output logic [31:0] dataIn,
    output logic [1:0]  dataSize,
    input  logic [31:0] dataOut,
    input  logic        memFuncComplete
);

    state_t          state;
    logic [TO_W-1:0] count;
    logic            req_signed;
    logic [31:0]     load_data;

    mem_access_ctrl_load_formatter u_fmt (
        .raw      (dataOut),
        .size     (dataSize),
        .sign_ext (req_signed),
        .data     (load_data)
    );

    // NOTE: every register here is written with <= so all of them sample the
    // same pre-edge values; a blocking write would leak into later statements.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state         <= ST_IDLE;
            count         <= '0;
            req_signed    <= 1'b0;
            reqReady      <= 1'b0;
            respValid     <= 1'b0;
            respRData     <= '0;
            respError     <= 1'b0;
            memFuncActive <= 1'b0;
            readWrite     <= 1'b0;
            address       <= '0;
            dataIn        <= '0;
            dataSize      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (reqValid && reqReady) begin
                        reqReady <= 1'b0;
                        if (is_illegal(reqAddr, reqSize)) begin
                            respValid <= 1'b1;
                            respError <= 1'b1;
                            respRData <= '0;
                            state     <= ST_DONE;
                        end else begin
                            // The RAM bus changes only here, a full cycle ahead of the strobe.
                            readWrite  <= reqWrite;
                            address    <= reqAddr;
                            dataIn     <= reqWData;
                            dataSize   <= reqSize;
                            req_signed <= reqSigned;
                            state      <= ST_SETUP;
                        end
                    end else begin
                        reqReady <= 1'b1;
                    end
                end

                ST_SETUP: begin
                    memFuncActive <= 1'b1;
                    count         <= '0;
                    state         <= ST_ACCESS;
                end

                ST_ACCESS: begin
                    if (memFuncComplete) begin
                        memFuncActive <= 1'b0;
                        respValid     <= 1'b1;
                        respError     <= 1'b0;
                        respRData     <= readWrite ? 32'h0 : load_data;
                        state         <= ST_DONE;
                    end else if (count == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        memFuncActive <= 1'b0;
                        respValid     <= 1'b1;
                        respError     <= 1'b1;
                        respRData     <= '0;
                        state         <= ST_DONE;
                    end else begin
                        count <= count + TO_W'(1);
                    end
                end

                ST_DONE: begin
                    if (respReady) begin
                        respValid <= 1'b0;
                        respError <= 1'b0;
                        respRData <= '0;
                        reqReady  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: byte-RAM stub, a byte-array response
// model fed at request acceptance, one per-cycle compare process and directed tests.
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqWrite = 1'b0;
    logic [8:0]  reqAddr = '0;
    logic [31:0] reqWData = '0;
    logic [1:0]  reqSize = '0;
    logic        reqSigned = 1'b0;
    logic        respValid;
    logic        respReady = 1'b0;
    logic [31:0] respRData;
    logic        respError;
    logic        memFuncActive;
    logic        readWrite;
    logic [8:0]  address;
    logic [31:0] dataIn;
    logic [1:0]  dataSize;
    logic [31:0] dataOut = '0;
    logic        memFuncComplete = 1'b0;

    always #5 Clk = ~Clk;

    mem_access_ctrl #(.TIMEOUT_CYCLES(15), .TO_W(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqAddr(reqAddr), .reqWData(reqWData), .reqSize(reqSize), .reqSigned(reqSigned),
        .respValid(respValid), .respReady(respReady), .respRData(respRData), .respError(respError),
        .memFuncActive(memFuncActive), .readWrite(readWrite), .address(address),
        .dataIn(dataIn), .dataSize(dataSize), .dataOut(dataOut), .memFuncComplete(memFuncComplete)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            0: return 8'h21;   1: return 8'h08;   2: return 8'h00;   3: return 8'h00;
            4: return 8'h00;   5: return 8'h00;   6: return 8'h01;   7: return 8'h80;
            11: return 8'h0F;  102: return 8'h00; 103: return 8'h00;
            508: return 8'h44; 509: return 8'h33; 510: return 8'h22; 511: return 8'h11;
            default: return 8'((i * 37 + 5) & 255);
        endcase
    endfunction

    // RAM stub: completes one cycle after the strobe, upper read bytes are junk.
    logic [7:0] ram_mem [512];
    logic       ram_loaded = 1'b0;
    logic       ram_dead = 1'b0;
    always @(posedge Clk) begin
        logic [31:0] junk;
        if (!ram_loaded) begin
            for (int i = 0; i < 512; i++) ram_mem[i] = init_byte(i);
            ram_loaded = 1'b1;
        end
        memFuncComplete <= memFuncActive && !ram_dead;
        if (memFuncActive && !memFuncComplete && !ram_dead) begin
            junk = $urandom();
            if (readWrite) begin
                ram_mem[address] <= dataIn[7:0];
                if (dataSize != SIZE_BYTE) ram_mem[9'(address + 1)] <= dataIn[15:8];
                if (dataSize == SIZE_WORD) begin
                    ram_mem[9'(address + 2)] <= dataIn[23:16];
                    ram_mem[9'(address + 3)] <= dataIn[31:24];
                end
            end else begin
                case (dataSize)
                    SIZE_WORD: dataOut <= {ram_mem[9'(address + 3)], ram_mem[9'(address + 2)],
                                           ram_mem[9'(address + 1)], ram_mem[address]};
                    SIZE_HALF: dataOut <= {junk[31:16], ram_mem[9'(address + 1)], ram_mem[address]};
                    default:   dataOut <= {junk[31:8], ram_mem[address]};
                endcase
            end
        end
    end

    int active_cycles = 0;
    always @(negedge Clk) if (memFuncActive) active_cycles++;

    // Response model: what a request must return, from the byte-array view of memory.
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic [7:0] ref_mem [512];
    logic       ref_loaded = 1'b0;
    resp_t      exp_q [$];

    function automatic logic bad_req(input logic [8:0] a, input logic [1:0] sz);
        return sz == 2'b10 || (sz == 2'b11 && a % 4 != 0) || (sz == 2'b01 && a % 2 != 0);
    endfunction

    function automatic resp_t model_resp(input logic wr, input logic [8:0] a, input logic [31:0] wd,
                                         input logic [1:0] sz, input logic sg);
        resp_t       r;
        int          nbytes;
        logic [31:0] acc;
        r.rdata = 32'h0;
        r.err   = 1'b0;
        if (bad_req(a, sz) || ram_dead) begin
            r.err = 1'b1;
            return r;
        end
        nbytes = (sz == 2'b11) ? 4 : (sz == 2'b01) ? 2 : 1;
        if (wr) begin
            for (int i = 0; i < nbytes; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
            return r;
        end
        acc = 32'h0;
        for (int i = 0; i < nbytes; i++) acc = acc + (32'(ref_mem[int'(a) + i]) << (8 * i));
        if (sg && nbytes < 4 && acc >= (32'd1 << (8 * nbytes - 1)))
            acc = acc - (32'd1 << (8 * nbytes));
        r.rdata = acc;
        return r;
    endfunction

    logic        cur_wr = 1'b0;
    logic [8:0]  cur_addr = '0;
    logic [31:0] cur_wdata = '0;
    logic [1:0]  cur_size = '0;
    logic        cur_legal = 1'b0;

    // Compare process: samples just after the falling edge, once inputs have settled.
    always @(negedge Clk) begin
        resp_t m;
        #1;
        if (!ref_loaded) begin
            for (int i = 0; i < 512; i++) ref_mem[i] = init_byte(i);
            ref_loaded = 1'b1;
        end
        if (!Reset) begin
            exp_q.delete();
        end else begin
            check("ready_valid_exclusive", 32'(reqReady & respValid), 0);
            if (memFuncActive) begin
                check("active_only_legal", 32'(cur_legal), 1);
                check("bus_readWrite", 32'(readWrite), 32'(cur_wr));
                check("bus_address", 32'(address), 32'(cur_addr));
                check("bus_dataIn", dataIn, cur_wdata);
                check("bus_dataSize", 32'(dataSize), 32'(cur_size));
            end
            if (respValid) begin
                check("resp_pending", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    check("model_rdata", respRData, exp_q[0].rdata);
                    check("model_error", 32'(respError), 32'(exp_q[0].err));
                    if (respReady) void'(exp_q.pop_front());
                end
            end
            if (reqValid && reqReady) begin
                m = model_resp(reqWrite, reqAddr, reqWData, reqSize, reqSigned);
                exp_q.push_back(m);
                cur_wr    = reqWrite;
                cur_addr  = reqAddr;
                cur_wdata = reqWData;
                cur_size  = reqSize;
                cur_legal = !bad_req(reqAddr, reqSize);
            end
        end
    end

    task automatic do_req(input logic wr, input logic [8:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic sgn, input int hold,
                          output logic [31:0] rdata, output logic err, output int lat);
        int guard = 0;
        @(negedge Clk);
        while (!reqReady && guard < 20) begin
            @(negedge Clk);
            guard++;
        end
        check("req_ready_seen", 32'(reqReady), 1);
        reqValid  = 1'b1;
        reqWrite  = wr;
        reqAddr   = addr;
        reqWData  = wdata;
        reqSize   = size;
        reqSigned = sgn;
        @(negedge Clk);
        reqValid = 1'b0;
        lat = 0;
        while (!respValid && lat < 40) begin
            @(negedge Clk);
            lat++;
        end
        check("resp_valid_seen", 32'(respValid), 1);
        rdata = respRData;
        err   = respError;
        for (int i = 0; i < hold; i++) begin
            @(negedge Clk);
            check("hold_valid", 32'(respValid), 1);
            check("hold_rdata", respRData, rdata);
            check("hold_req_ready_low", 32'(reqReady), 0);
        end
        respReady = 1'b1;
        @(negedge Clk);
        respReady = 1'b0;
        check("valid_cleared", 32'(respValid), 0);
        check("req_ready_back", 32'(reqReady), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] rd;
    logic        er;
    int          lt;
    int          act0;

    initial begin
        repeat (3) @(negedge Clk);
        check("rst_ctrl_outputs", {reqReady, respValid, respError, memFuncActive, readWrite}, 0);
        check("rst_bus_outputs", {address, dataSize}, 0);
        check("rst_dataIn", dataIn, 0);
        check("rst_respRData", respRData, 0);
        Reset = 1'b1;

        // Loads of preloaded data
        do_req(0, 9'd0, 0, SIZE_WORD, 0, 0, rd, er, lt);
        check("t1_word0_data", rd, 32'h00000821);
        check("t1_word0_err", 32'(er), 0);
        check("t1_latency", lt, 3);
        do_req(0, 9'd4, 0, SIZE_HALF, 0, 0, rd, er, lt);
        check("t2_half4_unsigned", rd, 32'h00000000);
        do_req(0, 9'd11, 0, SIZE_BYTE, 1, 0, rd, er, lt);
        check("t2_byte11_signed", rd, 32'h0000000F);
        do_req(0, 9'd6, 0, SIZE_HALF, 1, 0, rd, er, lt);
        check("half6_signed", rd, 32'hFFFF8001);
        do_req(0, 9'd6, 0, SIZE_HALF, 0, 0, rd, er, lt);
        check("half6_unsigned", rd, 32'h00008001);
        do_req(0, 9'd508, 0, SIZE_WORD, 0, 0, rd, er, lt);
        check("word508_top", rd, 32'h11223344);

        // Stores, then read back
        do_req(1, 9'd20, 32'h00000080, SIZE_BYTE, 0, 0, rd, er, lt);
        check("t3_store_rdata", rd, 0);
        check("t3_store_err", 32'(er), 0);
        do_req(0, 9'd20, 0, SIZE_BYTE, 1, 0, rd, er, lt);
        check("t3_byte20_signed", rd, 32'hFFFFFF80);
        do_req(0, 9'd20, 0, SIZE_BYTE, 0, 0, rd, er, lt);
        check("t3_byte20_unsigned", rd, 32'h00000080);
        do_req(1, 9'd100, 32'h1234ABCD, SIZE_HALF, 0, 0, rd, er, lt);
        do_req(0, 9'd100, 0, SIZE_WORD, 0, 0, rd, er, lt);
        check("store_half_readback", rd, 32'h0000ABCD);
        do_req(1, 9'd200, 32'hCAFEF00D, SIZE_WORD, 0, 0, rd, er, lt);
        do_req(0, 9'd200, 0, SIZE_WORD, 0, 0, rd, er, lt);
        check("store_word_readback", rd, 32'hCAFEF00D);

        // Illegal requests never strobe the RAM
        act0 = active_cycles;
        do_req(0, 9'd2, 0, SIZE_WORD, 0, 0, rd, er, lt);
        check("t4_misaligned_word_err", 32'(er), 1);
        check("t4_misaligned_word_rdata", rd, 0);
        check("t4_illegal_latency", lt, 0);
        do_req(0, 9'd0, 0, SIZE_BAD, 0, 0, rd, er, lt);
        check("t4_size10_err", 32'(er), 1);
        do_req(1, 9'd5, 32'hFFFF, SIZE_HALF, 0, 0, rd, er, lt);
        check("t4_misaligned_half_err", 32'(er), 1);
        check("t4_no_strobe", active_cycles - act0, 0);

        // Timeout with a RAM that never completes
        ram_dead = 1'b1;
        act0 = active_cycles;
        do_req(0, 9'd0, 0, SIZE_WORD, 0, 0, rd, er, lt);
        check("t5_timeout_err", 32'(er), 1);
        check("t5_timeout_rdata", rd, 0);
        check("t5_timeout_latency", lt, 16);
        check("t5_active_cycles", active_cycles - act0, 15);
        check("t5_active_dropped", 32'(memFuncActive), 0);
        ram_dead = 1'b0;

        // Reset in the middle of ACCESS
        @(negedge Clk);
        reqValid = 1'b1;
        reqWrite = 1'b0;
        reqAddr  = 9'd0;
        reqSize  = SIZE_WORD;
        @(negedge Clk);
        reqValid = 1'b0;
        @(negedge Clk);
        check("t6_in_access", 32'(memFuncActive), 1);
        Reset = 1'b0;
        @(negedge Clk);
        check("t6_rst_active", 32'(memFuncActive), 0);
        check("t6_rst_valid", 32'(respValid), 0);
        check("t6_rst_ready", 32'(reqReady), 0);
        Reset = 1'b1;
        do_req(0, 9'd0, 0, SIZE_WORD, 0, 0, rd, er, lt);
        check("t6_post_rst_data", rd, 32'h00000821);
        check("t6_post_rst_latency", lt, 3);

        // Consumer stalls in DONE
        do_req(0, 9'd11, 0, SIZE_BYTE, 1, 5, rd, er, lt);
        check("t7_stalled_data", rd, 32'h0000000F);

        repeat (3) @(negedge Clk);
        check("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
